// File: rtl/matmul_tile_sequencer_pkg.sv
// matmul_tile_sequencer_pkg: shared widths and FSM encoding for the tile sequencer
package matmul_tile_sequencer_pkg;
  localparam int AWIDTH_DEF = 11;
  localparam int TILE_W_DEF = 4;
  typedef enum logic [2:0] {
    S_IDLE, S_PE_CLR, S_START, S_WAIT, S_CLEAR, S_NEXT, S_DONE
  } state_t;
endpackage

// File: rtl/matmul_tile_addr_gen.sv
// matmul_tile_addr_gen: per-job address/tile-index registers with latched steps and last-tile compare
module matmul_tile_addr_gen
  import matmul_tile_sequencer_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int TILE_W = TILE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              adv,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic [AWIDTH-1:0] base_a,
  input  logic [AWIDTH-1:0] base_b,
  input  logic [AWIDTH-1:0] base_c,
  input  logic [AWIDTH-1:0] step_a,
  input  logic [AWIDTH-1:0] step_b,
  output logic [AWIDTH-1:0] addr_a,
  output logic [AWIDTH-1:0] addr_b,
  output logic [AWIDTH-1:0] addr_c,
  output logic [TILE_W-1:0] tile_idx,
  output logic              last
);
  logic [TILE_W-1:0] num_q;
  logic [AWIDTH-1:0] step_a_q, step_b_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_a   <= '0;
      addr_b   <= '0;
      addr_c   <= '0;
      tile_idx <= '0;
      num_q    <= '0;
      step_a_q <= '0;
      step_b_q <= '0;
    end else if (load) begin
      addr_a   <= base_a;
      addr_b   <= base_b;
      addr_c   <= base_c;
      tile_idx <= '0;
      num_q    <= num_tiles;
      step_a_q <= step_a;
      step_b_q <= step_b;
    end else if (adv) begin
      addr_a   <= addr_a + step_a_q;
      addr_b   <= addr_b + step_b_q;
      tile_idx <= tile_idx + TILE_W'(1);
    end
  end
  assign last = tile_idx == num_q - TILE_W'(1);
endmodule

// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: runs K-dimension tiles through the matmul wrapper start/done/clear handshake
module matmul_tile_sequencer
  import matmul_tile_sequencer_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int TILE_W = TILE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic [AWIDTH-1:0] cfg_base_a,
  input  logic [AWIDTH-1:0] cfg_base_b,
  input  logic [AWIDTH-1:0] cfg_base_c,
  input  logic [AWIDTH-1:0] cfg_step_a,
  input  logic [AWIDTH-1:0] cfg_step_b,
  input  logic              mm_done,
  output logic              mm_start_reg,
  output logic              mm_clear_done_reg,
  output logic              mm_pe_resetn,
  output logic [AWIDTH-1:0] mm_address_mat_a,
  output logic [AWIDTH-1:0] mm_address_mat_b,
  output logic [AWIDTH-1:0] mm_address_mat_c,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [TILE_W-1:0] tile_idx
);
  state_t state, state_n;
  logic abort_pend, abort_pend_n, aborted_n, load, adv, last, fin;
  matmul_tile_addr_gen #(.AWIDTH(AWIDTH), .TILE_W(TILE_W)) u_addr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .adv      (adv),
    .num_tiles(cfg_num_tiles),
    .base_a   (cfg_base_a),
    .base_b   (cfg_base_b),
    .base_c   (cfg_base_c),
    .step_a   (cfg_step_a),
    .step_b   (cfg_step_b),
    .addr_a   (mm_address_mat_a),
    .addr_b   (mm_address_mat_b),
    .addr_c   (mm_address_mat_c),
    .tile_idx (tile_idx),
    .last     (last)
  );
  assign fin = last | abort_pend | cfg_abort;
  always_comb begin
    state_n      = state;
    abort_pend_n = abort_pend;
    aborted_n    = aborted;
    load         = 1'b0;
    adv          = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (cfg_start) begin
        load         = 1'b1;
        abort_pend_n = 1'b0;
        aborted_n    = 1'b0;
        state_n      = cfg_num_tiles == '0 ? S_DONE : S_PE_CLR;
      end
      S_PE_CLR: begin
        state_n   = cfg_abort ? S_DONE : S_START;
        aborted_n = cfg_abort;
      end
      // start is already on the wire here, so an abort must let the tile finish
      S_START: begin
        state_n      = S_WAIT;
        abort_pend_n = abort_pend | cfg_abort;
      end
      S_WAIT: begin
        state_n      = mm_done ? S_CLEAR : S_WAIT;
        abort_pend_n = abort_pend | cfg_abort;
      end
      S_CLEAR: begin
        state_n      = mm_done ? S_CLEAR : S_NEXT;
        abort_pend_n = abort_pend | cfg_abort;
      end
      S_NEXT: begin
        state_n   = fin ? S_DONE : S_START;
        adv       = ~fin;
        aborted_n = abort_pend | cfg_abort;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      abort_pend        <= 1'b0;
      aborted           <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      mm_start_reg      <= 1'b0;
      mm_clear_done_reg <= 1'b0;
      mm_pe_resetn      <= 1'b1;
    end else begin
      state             <= state_n;
      abort_pend        <= abort_pend_n;
      aborted           <= aborted_n;
      busy              <= state_n != S_IDLE && state_n != S_DONE;
      done              <= state_n == S_DONE;
      mm_start_reg      <= state_n == S_START;
      mm_clear_done_reg <= state_n == S_CLEAR;
      mm_pe_resetn      <= state_n != S_PE_CLR;
    end
  end
endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb_matmul_tile_sequencer: directed jobs against a wrapper model, scoreboard of tile starts and job completions
module tb_matmul_tile_sequencer;
  typedef struct packed {
    logic [10:0] a, b, c;
    logic [3:0]  idx;
  } tile_t;
  typedef struct packed {
    logic        ab;
    logic [3:0]  idx;
    logic [7:0]  starts, clears, pes;
    logic [10:0] a, b, c;
  } job_t;
  logic clk = 0, reset = 1, cfg_start = 0, cfg_abort = 0, mm_done;
  logic [3:0]  cfg_num_tiles = 0;
  logic [10:0] cfg_base_a = 0, cfg_base_b = 0, cfg_base_c = 0, cfg_step_a = 0, cfg_step_b = 0;
  logic mm_start_reg, mm_clear_done_reg, mm_pe_resetn, busy, done, aborted;
  logic [10:0] addr_a, addr_b, addr_c;
  logic [3:0]  tile_idx;
  int vec = 0, bad = 0, cnt;
  tile_t tq[$];
  job_t  jq[$];
  tile_t tcur;
  job_t  jcur;
  logic [7:0] starts, clears, pes;
  logic clr_q, done_q;
  matmul_tile_sequencer dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_num_tiles(cfg_num_tiles), .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b),
    .cfg_base_c(cfg_base_c), .cfg_step_a(cfg_step_a), .cfg_step_b(cfg_step_b),
    .mm_done(mm_done), .mm_start_reg(mm_start_reg), .mm_clear_done_reg(mm_clear_done_reg),
    .mm_pe_resetn(mm_pe_resetn), .mm_address_mat_a(addr_a), .mm_address_mat_b(addr_b),
    .mm_address_mat_c(addr_c), .busy(busy), .done(done), .aborted(aborted), .tile_idx(tile_idx)
  );
  always #5 clk = ~clk;
  // wrapper model: done rises 20 cycles after start, falls one cycle after clear is seen
  always @(posedge clk) begin
    if (reset) begin
      cnt <= 0;
      mm_done <= 1'b0;
    end else begin
      if (mm_start_reg) cnt <= 20;
      else if (cnt > 1) cnt <= cnt - 1;
      else if (cnt == 1) begin
        cnt <= 0;
        mm_done <= 1'b1;
      end
      if (mm_clear_done_reg && mm_done) mm_done <= 1'b0;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      starts = 0; clears = 0; pes = 0; clr_q = 0; done_q = 0;
    end else begin
      if (!mm_pe_resetn) pes++;
      if (mm_clear_done_reg && !clr_q) clears++;
      if (mm_start_reg) begin
        starts++;
        if (tq.size() == 0) begin
          vec++; bad++;
          $display("FAIL unexpected start: idx %0d a %h", tile_idx, addr_a);
        end else begin
          tcur = tq.pop_front();
          chk("tile", {addr_a, addr_b, addr_c, tile_idx}, tcur);
        end
      end
      if (done && !done_q) begin
        if (jq.size() == 0) begin
          vec++; bad++;
          $display("FAIL unexpected job end: idx %0d", tile_idx);
        end else begin
          jcur = jq.pop_front();
          chk("job", {aborted, tile_idx, starts, clears, pes, addr_a, addr_b, addr_c}, jcur);
        end
        starts = 0; clears = 0; pes = 0;
      end
      clr_q = mm_clear_done_reg;
      done_q = done;
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_tile(input logic [10:0] a, b, c, input logic [3:0] idx);
    tq.push_back(tile_t'({a, b, c, idx}));
  endtask
  task automatic push_job(input logic ab, input logic [3:0] idx, input logic [7:0] s, cl, p,
                          input logic [10:0] a, b, c);
    jq.push_back(job_t'({ab, idx, s, cl, p, a, b, c}));
  endtask
  task automatic start_job(input logic [3:0] n, input logic [10:0] ba, bb, bc, sa, sb);
    cfg_num_tiles = n; cfg_base_a = ba; cfg_base_b = bb; cfg_base_c = bc;
    cfg_step_a = sa; cfg_step_b = sb; cfg_start = 1;
    tick();
    cfg_start = 0;
  endtask
  task automatic wait_done(input string nm);
    for (int i = 0; i < 400 && !done; i++) tick();
    chk(nm, done, 1);
  endtask
  task automatic wait_start(input string nm, input logic [3:0] idx);
    for (int i = 0; i < 200 && !(mm_start_reg && tile_idx == idx); i++) tick();
    chk(nm, mm_start_reg, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(3);
    reset = 0;
    chk("reset state", {busy, done, aborted, mm_start_reg, mm_clear_done_reg, mm_pe_resetn,
                        tile_idx, addr_a, addr_b, addr_c}, {6'b000001, 4'd0, 33'd0});
    // empty job
    push_job(0, 0, 0, 0, 0, 11'h010, 11'h020, 11'h030);
    start_job(0, 11'h010, 11'h020, 11'h030, 11'd4, 11'd4);
    chk("empty cycle1", {done, busy, mm_pe_resetn, mm_start_reg, mm_clear_done_reg}, 5'b10100);
    tick(3);
    chk("empty quiet", {busy, mm_pe_resetn, mm_start_reg, mm_clear_done_reg}, 4'b0100);
    // single tile
    push_tile(11'h000, 11'h100, 11'h200, 0);
    push_job(0, 0, 1, 1, 1, 11'h000, 11'h100, 11'h200);
    start_job(1, 11'h000, 11'h100, 11'h200, 11'd8, 11'd8);
    chk("t1 cycle1", {done, busy, mm_pe_resetn, mm_start_reg}, 4'b0100);
    chk("t1 addr cycle1", {addr_a, addr_b, addr_c}, {11'h000, 11'h100, 11'h200});
    tick();
    chk("t1 cycle2", {busy, mm_pe_resetn, mm_start_reg}, 3'b111);
    wait_done("t1 done");
    chk("t1 busy", busy, 0);
    tick(2);
    // three tiles
    push_tile(11'h000, 11'h100, 11'h200, 0);
    push_tile(11'h008, 11'h108, 11'h200, 1);
    push_tile(11'h010, 11'h110, 11'h200, 2);
    push_job(0, 2, 3, 3, 1, 11'h010, 11'h110, 11'h200);
    start_job(3, 11'h000, 11'h100, 11'h200, 11'd8, 11'd8);
    wait_done("t2 done");
    tick(2);
    // address wrap
    push_tile(11'h7FC, 11'h000, 11'h300, 0);
    push_tile(11'h004, 11'h000, 11'h300, 1);
    push_job(0, 1, 2, 2, 1, 11'h004, 11'h000, 11'h300);
    start_job(2, 11'h7FC, 11'h000, 11'h300, 11'd8, 11'd0);
    wait_done("t3 done");
    tick(2);
    // abort during WAIT of tile 1 of 4
    push_tile(11'h000, 11'h100, 11'h200, 0);
    push_tile(11'h004, 11'h104, 11'h200, 1);
    push_job(1, 1, 2, 2, 1, 11'h004, 11'h104, 11'h200);
    start_job(4, 11'h000, 11'h100, 11'h200, 11'd4, 11'd4);
    wait_start("t5 tile1 start", 1);
    tick(3);
    cfg_abort = 1;
    tick();
    cfg_abort = 0;
    chk("t5 still busy", busy, 1);
    wait_done("t5 done");
    tick(30);
    chk("t5 after abort", {busy, done, aborted, tile_idx}, {3'b011, 4'd1});
    push_tile(11'h020, 11'h120, 11'h220, 0);
    push_job(0, 0, 1, 1, 1, 11'h020, 11'h120, 11'h220);
    start_job(1, 11'h020, 11'h120, 11'h220, 11'd0, 11'd0);
    chk("t5 restart clears", {done, aborted, busy}, 3'b001);
    wait_done("t5 restart done");
    tick(2);
    // start while busy is ignored, then reset mid-job
    push_tile(11'h040, 11'h050, 11'h060, 0);
    start_job(2, 11'h040, 11'h050, 11'h060, 11'd1, 11'd1);
    wait_start("t6 start", 0);
    tick(3);
    start_job(5, 11'h111, 11'h222, 11'h333, 11'd2, 11'd2);
    tick();
    chk("t6 busy start ignored", {busy, tile_idx, addr_a, addr_b, addr_c},
        {1'b1, 4'd0, 11'h040, 11'h050, 11'h060});
    reset = 1;
    tick();
    chk("t6 reset", {busy, done, aborted, mm_start_reg, mm_clear_done_reg, mm_pe_resetn,
                     tile_idx, addr_a, addr_b, addr_c}, {6'b000001, 4'd0, 33'd0});
    reset = 0;
    tick(30);
    chk("t6 idle after reset", {busy, done, mm_start_reg}, 3'b000);
    chk("tile queue drained", tq.size(), 0);
    chk("job queue drained", jq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/matmul_tile_sequencer.md
Name: matmul_tile_sequencer

Overview:
Job-level controller that drives the start/done/clear handshake of the 8x8 matrix_multiplication wrapper over a sequence of K-dimension tiles. For each job it clears the PE accumulators once, then runs N tiles back to back. Per tile it advances the A/B base addresses by programmed steps; C stays fixed so results accumulate. It sits between the register bank (config/status) and the matmul wrapper's start_reg/clear_done_reg/address/pe_resetn inputs.

Parameters:
AWIDTH, 11, BRAM address width (matches wrapper address_mat_* ports)
TILE_W, 4, width of tile count/index (max 15 tiles per job)

Ports:
clk  in  1  single clock; the matmul controller is also clocked by clk
reset  in  1  synchronous, active-high reset
cfg_start  in  1  one-cycle job start request
cfg_abort  in  1  one-cycle abort request
cfg_num_tiles  in  TILE_W  tiles in the job; 0 means an empty job
cfg_base_a / cfg_base_b / cfg_base_c  in  AWIDTH  first-tile base addresses
cfg_step_a / cfg_step_b  in  AWIDTH  per-tile address increments
mm_done  in  1  level; high while the matmul wrapper is in its done state
mm_start_reg  out  1  to wrapper start_reg
mm_clear_done_reg  out  1  to wrapper clear_done_reg
mm_pe_resetn  out  1  to wrapper pe_resetn (active-low)
mm_address_mat_a / _b / _c  out  AWIDTH  to wrapper address_mat_*
busy  out  1  job in progress
done  out  1  job finished; sticky
aborted  out  1  last job ended by abort; sticky
tile_idx  out  TILE_W  index of current or last tile

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset); all state updates on posedge clk.
- Reset values: busy=0, done=0, aborted=0, mm_start_reg=0, mm_clear_done_reg=0, mm_pe_resetn=1, mm_address_*=0, tile_idx=0, state=IDLE. Reset mid-job returns to IDLE immediately; the block does not wait for mm_done.
- FSM states: IDLE, PE_CLR, START, WAIT, CLEAR, NEXT, DONE. All outputs are registered.
- IDLE/DONE + cfg_start:
  - Latch all cfg_* fields. Load mm_address_a/b/c with the bases. tile_idx=0. done=0, aborted=0.
  - If cfg_num_tiles==0: go to DONE with done=1 next cycle. No pe/start activity.
  - Otherwise go to PE_CLR with busy=1.
- PE_CLR: mm_pe_resetn=0 for exactly one cycle, then START.
- START: mm_start_reg=1 for exactly one cycle, then WAIT.
- WAIT: hold until mm_done==1, then CLEAR.
- CLEAR: mm_clear_done_reg=1, held until mm_done==0, then NEXT. This tolerates the wrapper's one-cycle clear latency.
- NEXT (one cycle):
  - If tile_idx==num_tiles-1 or abort is pending: go to DONE (busy=0, done=1).
  - Otherwise: tile_idx+1, mm_address_a += step_a, mm_address_b += step_b (both modulo 2^AWIDTH, wrap silently; C unchanged), then START.
- Latency: cfg_start in cycle 0 gives busy=1 and mm_pe_resetn=0 in cycle 1, and mm_start_reg=1 in cycle 2. Addresses are valid from cycle 1 and stable for the whole tile.
- Abort:
  - In IDLE/DONE: ignored.
  - In PE_CLR/START: go to DONE with aborted=1. No further tiles start. If mm_start_reg was already issued, continue through WAIT/CLEAR first.
  - In WAIT/CLEAR: set abort_pending; the current tile completes its handshake (the wrapper cannot be cancelled); DONE with aborted=1.
- Simultaneous cfg_start and cfg_abort in IDLE/DONE: start wins.
- cfg_start while busy: ignored; latched config is not disturbed.
- done/aborted stay high until the next accepted cfg_start or reset.

Decomposition:
- Shared package: FSM state encoding constants, AWIDTH and TILE_W defaults, consistent with the codebase `define set.
- One natural sub-module, matmul_tile_addr_gen: holds the three address registers and tile_idx, with load/advance controls and the last-tile compare. The FSM lives in the top.

Test Plan:
1. Single tile: num_tiles=1, bases 0x000/0x100/0x200. Model mm_done rising 20 cycles after start and falling 1 cycle after clear. Expect: pe_resetn low in cycle 1; start pulse in cycle 2; one clear; done=1; busy=0; addresses unchanged.
2. Three tiles: step_a=8, step_b=8. Expect three start pulses. mm_address_a goes 0x000, 0x008, 0x010 and mm_address_b 0x100, 0x108, 0x110. C stays 0x200; pe_resetn pulses only once; tile_idx ends at 2.
3. Wrap: base_a=0x7FC, step_a=8, 2 tiles. Expect second-tile mm_address_a=0x004.
4. Empty job: num_tiles=0. Expect done=1 one cycle after cfg_start; no start, clear or pe_resetn activity.
5. Abort in WAIT of tile 1 of 4: expect tile 1 completes clear, then done=1 and aborted=1. No further start, tile_idx=1. A later cfg_start clears aborted.
6. Reset asserted in WAIT: all outputs return to their reset values next cycle. cfg_start while busy is ignored (checked by a mid-job cfg_start with different bases; addresses unchanged).
